// File: rtl/wm_pkg.sv
// Shared types for the washing-machine front-panel sequencer.
package wm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_REQ = 3'd1,
    ST_RUN       = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_COMPLETE  = 3'd4,
    ST_FAULT     = 3'd5
  } panel_state_e;

  function automatic logic state_busy(input panel_state_e st);
    return (st == ST_START_REQ) || (st == ST_RUN) || (st == ST_PAUSED);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-count debounce; press is a one-cycle
// pulse on the accepted level's rising transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // synchronize raw input and accept a new level after a full stable run
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == LAST_CNT) begin
        level_r <= sync2_r;
        press_r <= sync2_r;
        cnt_r   <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/wm_panel_ctrl.sv
// Front-panel sequencer: debounced buttons drive start/option/pause commands
// to the washer, with ack timeout fault and saturating completion counter.
module wm_panel_ctrl
  import wm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_pause,
  input  logic             btn_double,
  input  logic             btn_dry,
  input  logic             wm_done,
  output logic             start,
  output logic             double_wash,
  output logic             dry_wash,
  output logic             time_pause,
  output logic             busy,
  output logic             fault,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_ACK = AW'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  panel_state_e     state_r;
  panel_state_e     next_s;
  logic             start_p_s;
  logic             pause_p_s;
  logic             dbl_p_s;
  logic             dry_p_s;
  logic [3:0]       unused_levels_s;
  logic             dbl_sel_r;
  logic             dry_sel_r;
  logic             dbl_next_s;
  logic             dry_next_s;
  logic [AW-1:0]    ack_cnt_r;
  logic [AW-1:0]    ack_next_s;
  logic             wm_done_prev_r;
  logic             done_rise_s;
  logic             start_r;
  logic             double_wash_r;
  logic             dry_wash_r;
  logic             time_pause_r;
  logic             busy_r;
  logic             fault_r;
  logic             cycle_done_r;
  logic [CNT_W-1:0] cycle_count_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .raw(btn_start), .level(unused_levels_s[0]), .press(start_p_s));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk(clk), .rst(rst), .raw(btn_pause), .level(unused_levels_s[1]), .press(pause_p_s));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_double (
    .clk(clk), .rst(rst), .raw(btn_double), .level(unused_levels_s[2]), .press(dbl_p_s));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dry (
    .clk(clk), .rst(rst), .raw(btn_dry), .level(unused_levels_s[3]), .press(dry_p_s));

  assign done_rise_s = wm_done & ~wm_done_prev_r;

  // next-state, selection latch and ack-timer decisions
  always_comb begin
    next_s     = state_r;
    dbl_next_s = dbl_sel_r;
    dry_next_s = dry_sel_r;
    ack_next_s = {AW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        // a start press swallows any option press arriving with it
        if (start_p_s) begin
          next_s = ST_START_REQ;
        end else if (dry_p_s) begin
          dry_next_s = ~dry_sel_r;
          dbl_next_s = 1'b0;
        end else if (dbl_p_s) begin
          dbl_next_s = ~dbl_sel_r;
          dry_next_s = 1'b0;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_START_REQ: begin
        if (!wm_done) begin
          next_s = ST_RUN;
        end else if (ack_cnt_r == LAST_ACK) begin
          next_s = ST_FAULT;
        end else begin
          ack_next_s = ack_cnt_r + AW'(1);
        end
      end
      ST_RUN: begin
        if (done_rise_s) begin
          next_s = ST_COMPLETE;
        end else if (pause_p_s) begin
          next_s = ST_PAUSED;
        end else begin
          next_s = ST_RUN;
        end
      end
      ST_PAUSED: begin
        if (done_rise_s) begin
          next_s = ST_COMPLETE;
        end else if (pause_p_s) begin
          next_s = ST_RUN;
        end else begin
          next_s = ST_PAUSED;
        end
      end
      ST_COMPLETE: begin
        next_s = ST_IDLE;
      end
      ST_FAULT: begin
        if (start_p_s) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_FAULT;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // state, selections, timer and registered outputs derived from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      dbl_sel_r      <= 1'b0;
      dry_sel_r      <= 1'b0;
      ack_cnt_r      <= {AW{1'b0}};
      wm_done_prev_r <= 1'b0;
      start_r        <= 1'b0;
      double_wash_r  <= 1'b0;
      dry_wash_r     <= 1'b0;
      time_pause_r   <= 1'b0;
      busy_r         <= 1'b0;
      fault_r        <= 1'b0;
      cycle_done_r   <= 1'b0;
      cycle_count_r  <= {CNT_W{1'b0}};
    end else begin
      state_r        <= next_s;
      dbl_sel_r      <= dbl_next_s;
      dry_sel_r      <= dry_next_s;
      ack_cnt_r      <= ack_next_s;
      wm_done_prev_r <= wm_done;
      start_r        <= (next_s == ST_START_REQ);
      double_wash_r  <= state_busy(next_s) & dbl_next_s;
      dry_wash_r     <= (next_s == ST_START_REQ) & dry_next_s;
      time_pause_r   <= (next_s == ST_PAUSED);
      busy_r         <= state_busy(next_s);
      fault_r        <= (next_s == ST_FAULT);
      cycle_done_r   <= (next_s == ST_COMPLETE);
      if ((next_s == ST_COMPLETE) && (cycle_count_r != CNT_MAX)) begin
        cycle_count_r <= cycle_count_r + CNT_W'(1);
      end else begin
        cycle_count_r <= cycle_count_r;
      end
    end
  end

  assign start       = start_r;
  assign double_wash = double_wash_r;
  assign dry_wash    = dry_wash_r;
  assign time_pause  = time_pause_r;
  assign busy        = busy_r;
  assign fault       = fault_r;
  assign cycle_done  = cycle_done_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: doc/wm_panel_ctrl.md
Name: wm_panel_ctrl

Overview:
Front-panel sequencer that drives the washing-machine controller's command inputs (start, double_wash, dry_wash, time_pause) and consumes its done output. It debounces raw user buttons, latches the program selection, issues the start request and pause/resume, and detects cycle completion. It also flags a fault when the washer never acknowledges a start, and keeps a saturating count of completed cycles.

Parameters:
DEBOUNCE_CYCLES, 4, number of consecutive identical synchronized samples before a button level is accepted (minimum 1)
ACK_TIMEOUT, 16, clock cycles allowed in START_REQ for wm_done to go low before FAULT
CNT_W, 8, width of cycle_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
btn_start  input  1  raw start/clear button, asynchronous, active-high
btn_pause  input  1  raw pause/resume toggle button
btn_double  input  1  raw double-wash select toggle
btn_dry  input  1  raw dry-wash select toggle
wm_done  input  1  washer done; high after a cycle completes, stays high until the next start is accepted
start  output  1  start request to washer
double_wash  output  1  double-wash option to washer
dry_wash  output  1  dry-wash option to washer
time_pause  output  1  pause request to washer
busy  output  1  high in START_REQ, RUN and PAUSED
fault  output  1  high in FAULT
cycle_done  output  1  one-cycle pulse on completion
cycle_count  output  CNT_W  completed cycles, saturates at all-ones

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. On rst: state IDLE, every output 0, selection latches 0, cycle_count 0, debouncers cleared (accepted level 0, no pulse).
- Buttons: 2-flop synchronizer, then stable-count debounce. A press is a one-cycle pulse on the accepted level's 0->1 transition. Latency from a clean raw edge to the pulse is 2 + DEBOUNCE_CYCLES cycles. Any bounce restarts the count.
- Selection latches dbl_sel and dry_sel change only in IDLE. A btn_double press toggles dbl_sel and clears dry_sel. A btn_dry press toggles dry_sel and clears dbl_sel. The two are never both 1. If both presses arrive in the same cycle, dry wins.
- IDLE: outputs low. A start press moves to START_REQ. Pause presses are ignored. A start press wins over option presses in the same cycle; those option presses are dropped.
- START_REQ: start=1, dry_wash=dry_sel, double_wash=dbl_sel, and the ack timer counts up. The state lasts at least one cycle. When wm_done==0 is sampled, go to RUN. If the timer reaches ACK_TIMEOUT first, go to FAULT. If wm_done is already 0 on entry, ack on the first cycle.
- RUN: start=0, dry_wash=0, double_wash=dbl_sel (held so the washer can test it at the end of rinse). A wm_done 0->1 edge (registered previous value) goes to COMPLETE. A pause press goes to PAUSED. If both happen in the same cycle, done wins.
- PAUSED: time_pause=1, double_wash=dbl_sel. A pause press returns to RUN. A wm_done 0->1 edge goes to COMPLETE and has priority.
- COMPLETE (1 cycle): cycle_done=1, cycle_count increments and holds at 2^CNT_W-1. Next state is IDLE. Selections are retained.
- FAULT: fault=1, all washer outputs low. A start press returns to IDLE, and that press does not also start a cycle. Start presses in START_REQ, RUN and PAUSED are ignored.
- Reset mid-operation: start and time_pause drop on the reset edge. This block never resets the washer.
- Outputs are registered; washer-facing signals change one cycle after the state decision.

Decomposition:
- Shared package wm_pkg: panel state enum (IDLE, START_REQ, RUN, PAUSED, COMPLETE, FAULT).
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, raw, level, press), instantiated four times.

Test Plan:
- rst=1 for 2 cycles, buttons toggled during reset -> all outputs 0 and cycle_count=0 after release.
- btn_double press, then btn_start press; model keeps wm_done=1 for 3 cycles after start, then drops it -> start high 3+ cycles, double_wash=1 through RUN, busy=1. After wm_done rises: cycle_done pulses once, cycle_count=1, state IDLE.
- btn_dry press, then start -> dry_wash=1 only while start=1 and dry_wash=0 in RUN; dbl_sel cleared.
- In RUN, pause press -> time_pause=1; a second pause press -> time_pause=0. A pause press coincident with the wm_done rise -> COMPLETE, time_pause stays 0.
- Start with wm_done held 1 -> after 16 cycles fault=1 and start=0. A start press -> IDLE, fault=0, no new start.
- Raw button chattering 3 cycles on / 1 off, DEBOUNCE_CYCLES=4 -> no press pulse. Held 6 cycles -> exactly one pulse.
